conv_stream: RTL and testbench

Parametrised streaming 2-D convolution layer: the general successor to the fixed 28x28 / 3x3 / 16-filter first conv stage. Pixels arrive in raster order over a valid/ready stream with IN_CH channels packed per beat. A (K-1)-row line buffer builds each KxK window, and one shared MAC datapath emits all NUM_F filter results for that window over a valid/ready output stream. Weights and biases live in internal registers written through a load port while the block is idle. The block sits between the image source and the next CNN stage.

---
 rtl/conv_stream_if.sv | 50 +++++
 rtl/conv_stream.sv | 239 +++++++++++++++++++++++
 tb/tb_conv_stream.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_if.sv
// Bundle of conv_stream control, weight/bias load, pixel-in and result-out signals.
// The slave modport is the conv_stream side; master is the driver/consumer side.
interface conv_stream_if #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int IN_CH = 1,
   parameter int NUM_F = 16,
   parameter int DW    = 8,
   parameter int ACC_W = 32
);
   localparam int WA_W = (NUM_F*IN_CH*K*K > 1) ? $clog2(NUM_F*IN_CH*K*K) : 1;
   localparam int F_W  = (NUM_F > 1) ? $clog2(NUM_F) : 1;
   localparam int OR_W = (IMG_H-K+1 > 1) ? $clog2(IMG_H-K+1) : 1;
   localparam int OC_W = (IMG_W-K+1 > 1) ? $clog2(IMG_W-K+1) : 1;

   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  w_we;
   logic [WA_W-1:0]       w_addr;
   logic [DW-1:0]         w_data;
   logic                  b_we;
   logic [F_W-1:0]        b_addr;
   logic [ACC_W-1:0]      b_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [IN_CH*DW-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      out_data;
   logic [F_W-1:0]        out_f;
   logic [OR_W-1:0]       out_row;
   logic [OC_W-1:0]       out_col;
   logic                  out_last;

   modport slave (
      input  start, w_we, w_addr, w_data, b_we, b_addr, b_data,
             in_valid, in_data, out_ready,
      output busy, done, in_ready, out_valid, out_data, out_f,
             out_row, out_col, out_last
   );

   modport master (
      output start, w_we, w_addr, w_data, b_we, b_addr, b_data,
             in_valid, in_data, out_ready,
      input  busy, done, in_ready, out_valid, out_data, out_f,
             out_row, out_col, out_last
   );
endinterface

// File: rtl/conv_stream.sv
// Streaming KxK convolution, NUM_F filters per window; first result one cycle after the completing beat, one result per out handshake.
// Input is stalled (in_ready=0) for the whole EMIT phase; results hold while out_ready=0. CONV_STREAM_RELU_EN clamps negative sums to 0.
module conv_stream #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int IN_CH = 1,
   parameter int NUM_F = 16,
   parameter int DW    = 8,
   parameter int ACC_W = 32
) (
   input logic          clk,
   input logic          reset_n,
   conv_stream_if.slave bus
);
   localparam int TAPS   = IN_CH*K*K;
   localparam int NW     = NUM_F*TAPS;
   localparam int WA_W   = (NW > 1) ? $clog2(NW) : 1;
   localparam int F_W    = (NUM_F > 1) ? $clog2(NUM_F) : 1;
   localparam int OR_W   = (IMG_H-K+1 > 1) ? $clog2(IMG_H-K+1) : 1;
   localparam int OC_W   = (IMG_W-K+1 > 1) ? $clog2(IMG_W-K+1) : 1;
   localparam int R_W    = (IMG_H > 1) ? $clog2(IMG_H) + 1 : 1;
   localparam int C_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int PW     = IN_CH*DW;
   localparam int LB_LEN = (K-1)*IMG_W;

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_EMIT, ST_DONE} state_t;

   state_t                  r_state;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_out_last;
   logic                    r_final;
   logic [R_W-1:0]          r_row;
   logic [C_W-1:0]          r_col;
   logic [F_W-1:0]          r_f;
   logic [OR_W-1:0]         r_out_row;
   logic [OC_W-1:0]         r_out_col;
   logic [ACC_W-1:0]        r_out_data;

   logic signed [DW-1:0]    r_w   [NUM_F][IN_CH][K][K];
   logic signed [ACC_W-1:0] r_b   [NUM_F];
   logic [PW-1:0]           r_lb  [LB_LEN];
   logic signed [DW-1:0]    r_win [IN_CH][K][K];

   logic signed [DW-1:0]    w_col_new [IN_CH][K];
   logic signed [DW-1:0]    w_win_nxt [IN_CH][K][K];
   logic signed [ACC_W-1:0] w_acc     [TAPS+1];
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_res;
   logic [F_W-1:0]          w_fsel;
   logic                    w_wr_en;
   logic                    w_acc_in;
   logic                    w_win_done;
   logic                    w_last_px;

   assign w_wr_en    = (r_state == ST_IDLE);
   assign w_acc_in   = r_in_ready && bus.in_valid;
   assign w_win_done = (r_row >= R_W'(K-1)) && (r_col >= C_W'(K-1));
   assign w_last_px  = (r_row == R_W'(IMG_H-1)) && (r_col == C_W'(IMG_W-1));

   // Coefficient store: writable only while idle so a running image sees a fixed kernel.
   for (genvar f = 0; f < NUM_F; f++) begin : g_f
      for (genvar ch = 0; ch < IN_CH; ch++) begin : g_ch
         for (genvar m = 0; m < K; m++) begin : g_m
            for (genvar n = 0; n < K; n++) begin : g_n
               always_ff @(posedge clk or negedge reset_n) begin
                  if (!reset_n) begin
                     r_w[f][ch][m][n] <= '0;
                  end else if (w_wr_en && bus.w_we &&
                               bus.w_addr == WA_W'(((f*IN_CH+ch)*K+m)*K+n)) begin
                     r_w[f][ch][m][n] <= bus.w_data;
                  end
               end
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_b[f] <= '0;
         end else if (w_wr_en && bus.b_we && bus.b_addr == F_W'(f)) begin
            r_b[f] <= bus.b_data;
         end
      end
   end

   // Line buffer is one shift chain; row r-j of the current column sits j*IMG_W-1 deep.
   for (genvar i = 0; i < LB_LEN; i++) begin : g_lb
      if (i == 0) begin : g_head
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)      r_lb[i] <= '0;
            else if (w_acc_in) r_lb[i] <= bus.in_data;
         end
      end else begin : g_tail
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)      r_lb[i] <= '0;
            else if (w_acc_in) r_lb[i] <= r_lb[i-1];
         end
      end
   end

   for (genvar ch = 0; ch < IN_CH; ch++) begin : g_wch
      for (genvar m = 0; m < K; m++) begin : g_wm
         if (m == K-1) begin : g_new
            assign w_col_new[ch][m] = bus.in_data[ch*DW +: DW];
         end else begin : g_old
            assign w_col_new[ch][m] = r_lb[(K-1-m)*IMG_W-1][ch*DW +: DW];
         end

         for (genvar n = 0; n < K; n++) begin : g_wn
            if (n == K-1) begin : g_in
               assign w_win_nxt[ch][m][n] = w_col_new[ch][m];
            end else begin : g_sh
               assign w_win_nxt[ch][m][n] = r_win[ch][m][n+1];
            end

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n)      r_win[ch][m][n] <= '0;
               else if (w_acc_in) r_win[ch][m][n] <= w_win_nxt[ch][m][n];
            end
         end
      end
   end

   // Shared MAC: filter 0 on the incoming window while streaming, next filter while emitting.
   assign w_fsel   = (r_state == ST_EMIT) ? r_f + F_W'(1) : '0;
   assign w_acc[0] = r_b[w_fsel];

   for (genvar ch = 0; ch < IN_CH; ch++) begin : g_mch
      for (genvar m = 0; m < K; m++) begin : g_mm
         for (genvar n = 0; n < K; n++) begin : g_mn
            localparam int T = (ch*K+m)*K+n;
            logic signed [DW-1:0]   w_px;
            logic signed [2*DW-1:0] w_prod;
            assign w_px     = (r_state == ST_STREAM) ? w_win_nxt[ch][m][n] : r_win[ch][m][n];
            assign w_prod   = w_px * r_w[w_fsel][ch][m][n];
            assign w_acc[T+1] = w_acc[T] + ACC_W'(w_prod);
         end
      end
   end

   assign w_sum = w_acc[TAPS];

`ifdef CONV_STREAM_RELU_EN
   assign w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
   assign w_res = w_sum;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_last  <= 1'b0;
         r_final     <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_f         <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state    <= ST_STREAM;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_f        <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (w_acc_in) begin
                  if (r_col == C_W'(IMG_W-1)) begin
                     r_col <= '0;
                     r_row <= r_row + R_W'(1);
                  end else begin
                     r_col <= r_col + C_W'(1);
                  end
                  if (w_win_done) begin
                     r_state     <= ST_EMIT;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_f         <= '0;
                     r_out_data  <= w_res;
                     r_out_row   <= OR_W'(r_row - R_W'(K-1));
                     r_out_col   <= OC_W'(r_col - C_W'(K-1));
                     r_final     <= w_last_px;
                     r_out_last  <= w_last_px && (NUM_F == 1);
                  end
               end
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  if (r_f == F_W'(NUM_F-1)) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     if (r_final) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= ST_STREAM;
                        r_in_ready <= 1'b1;
                     end
                  end else begin
                     r_f        <= r_f + F_W'(1);
                     r_out_data <= w_res;
                     r_out_last <= r_final && (r_f == F_W'(NUM_F-2));
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_f     = r_f;
   assign bus.out_row   = r_out_row;
   assign bus.out_col   = r_out_col;
   assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_conv_stream.sv
// Directed bench for conv_stream at default parameters: full images under several weight/pixel patterns,
// output backpressure, writes attempted while busy, and a mid-image reset.
module tb_conv_stream;
   localparam int W     = 28;
   localparam int H     = 28;
   localparam int K     = 3;
   localparam int NF    = 16;
   localparam int OW    = W-K+1;
   localparam int OH    = H-K+1;
   localparam int NOUT  = OW*OH*NF;
   localparam int NW    = NF*K*K;
   localparam int LIMIT = 13000;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   conv_stream_if bus_if ();
   conv_stream dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

   int checks   = 0;
   int failures = 0;
   int tw [NF][K][K];
   int tb_b [NF];
   logic signed [31:0] res      [NOUT];
   logic signed [31:0] res_prev [NOUT];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pix(input int mode, input int r, input int c);
      return (mode == 1) ? r + c : 1;
   endfunction

   function automatic logic signed [31:0] model(input int mode, input int f, input int r, input int c);
      int s;
      s = tb_b[f];
      for (int m = 0; m < K; m++)
         for (int n = 0; n < K; n++)
            s += pix(mode, r+m, c+n) * tw[f][m][n];
`ifdef CONV_STREAM_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   task automatic load(input int wmode);
      for (int i = 0; i < NW; i++) begin
         int f, m, n, v, bv;
         f = i / (K*K);
         m = (i % (K*K)) / K;
         n = i % K;
         v = (wmode == 0) ? 1 : (wmode == 1) ? ((f == 3 && m == 1 && n == 1) ? 1 : 0) : -1;
         tw[f][m][n] = v;
         @(negedge clk);
         bus_if.w_we   = 1'b1;
         bus_if.w_addr = 8'(i);
         bus_if.w_data = 8'(v);
         if (i < NF) begin
            bv = (wmode == 0) ? 0 : (wmode == 1) ? ((i == 3) ? 0 : 7*i) : 5;
            tb_b[i]       = bv;
            bus_if.b_we   = 1'b1;
            bus_if.b_addr = 4'(i);
            bus_if.b_data = 32'(bv);
         end else begin
            bus_if.b_we = 1'b0;
         end
      end
      @(negedge clk);
      bus_if.w_we = 1'b0;
      bus_if.b_we = 1'b0;
   endtask

   task automatic run_image(input string nm, input int mode, input int stall_at,
                            input bit busy_wr, input int abort_after);
      int px, nout, cyc, busy_cyc, done_cnt, last_cnt, bad_data, bad_ord, bad_tim;
      int stall_left, q, er, ec, ef, r, c, exp_r, exp_c;
      bit exp_emit, stalled, aborted;
      logic [45:0] hold;
      px = 0; nout = 0; busy_cyc = 0; done_cnt = 0; last_cnt = 0;
      bad_data = 0; bad_ord = 0; bad_tim = 0; stall_left = 0;
      exp_emit = 0; stalled = 0; aborted = 0; exp_r = 0; exp_c = 0; hold = '0;

      @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      chk({nm, "_start_busy_rdy"}, {bus_if.busy, bus_if.in_ready}, 2'b11);

      for (cyc = 0; cyc < LIMIT; cyc++) begin
         if (bus_if.busy !== 1'b1) break;
         busy_cyc++;
         if (bus_if.done === 1'b1) done_cnt++;
         if (exp_emit) begin
            if (!(bus_if.out_valid === 1'b1 && bus_if.out_f === 4'd0 && bus_if.in_ready === 1'b0 &&
                  bus_if.out_row === 5'(exp_r) && bus_if.out_col === 5'(exp_c)))
               bad_tim++;
            exp_emit = 0;
         end

         if (!stalled && stall_at >= 0 && nout == stall_at && bus_if.out_valid === 1'b1) begin
            stalled    = 1;
            stall_left = 7;
            hold = {bus_if.out_data, bus_if.out_f, bus_if.out_row, bus_if.out_col};
         end else if (stall_left > 0) begin
            chk({nm, "_stall_hold"},
                {bus_if.out_data, bus_if.out_f, bus_if.out_row, bus_if.out_col,
                 bus_if.in_ready, bus_if.out_valid}, {hold, 2'b01});
         end
         bus_if.out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;

         bus_if.in_valid = (px < W*H);
         bus_if.in_data  = 8'(pix(mode, px / W, px % W));
         if (busy_wr) begin
            bus_if.w_we   = 1'b1;
            bus_if.w_addr = 8'(cyc % NW);
            bus_if.w_data = 8'd77;
            bus_if.b_we   = 1'b1;
            bus_if.b_addr = 4'(cyc % NF);
            bus_if.b_data = 32'd1000;
         end

         if (bus_if.in_valid && bus_if.in_ready === 1'b1) begin
            r = px / W;
            c = px % W;
            if (r >= K-1 && c >= K-1) begin
               exp_emit = 1;
               exp_r = r - (K-1);
               exp_c = c - (K-1);
            end
            px++;
         end
         if (bus_if.out_valid === 1'b1 && bus_if.out_ready) begin
            q  = nout / NF;
            er = q / OW;
            ec = q % OW;
            ef = nout % NF;
            if (bus_if.out_row !== 5'(er) || bus_if.out_col !== 5'(ec) || bus_if.out_f !== 4'(ef))
               bad_ord++;
            if (bus_if.out_last !== (nout == NOUT-1)) bad_ord++;
            if (bus_if.out_last === 1'b1) last_cnt++;
            if (nout < NOUT) begin
               if ($signed(bus_if.out_data) !== model(mode, ef, er, ec)) bad_data++;
               res[nout] = bus_if.out_data;
            end
            nout++;
         end
         @(negedge clk);
         if (abort_after >= 0 && px >= abort_after) begin
            aborted = 1;
            break;
         end
      end

      bus_if.w_we     = 1'b0;
      bus_if.b_we     = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.out_ready = 1'b1;
      if (aborted) return;

      chk({nm, "_no_timeout"}, cyc < LIMIT, 1);
      chk({nm, "_count"}, nout, NOUT);
      chk({nm, "_data_errs"}, bad_data, 0);
      chk({nm, "_order_last_errs"}, bad_ord, 0);
      chk({nm, "_emit_timing_errs"}, bad_tim, 0);
      chk({nm, "_last_cnt"}, last_cnt, 1);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_cycles"}, busy_cyc + 1, (stall_at >= 0) ? 11609 : 11602);
      chk({nm, "_idle_after"}, {bus_if.busy, bus_if.done, bus_if.in_ready, bus_if.out_valid}, 4'b0000);
   endtask

   initial begin
      bus_if.start     = 1'b0;
      bus_if.w_we      = 1'b0;
      bus_if.w_addr    = '0;
      bus_if.w_data    = '0;
      bus_if.b_we      = 1'b0;
      bus_if.b_addr    = '0;
      bus_if.b_data    = '0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b1;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #20;
      chk("rst_flags", {bus_if.in_ready, bus_if.out_valid, bus_if.out_last, bus_if.busy, bus_if.done}, 5'b0);
      chk("rst_out_data", bus_if.out_data, 0);
      chk("rst_coords", {bus_if.out_f, bus_if.out_row, bus_if.out_col}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // all-ones kernel and image
      load(0);
      run_image("ones", 0, -1, 0, -1);
      chk("ones_first", res[0], 9);
      chk("ones_final", res[NOUT-1], 9);

      // filter 3 picks the window centre, others emit bias only
      load(1);
      run_image("centre", 1, -1, 0, -1);
      chk("centre_f3_00", res[3], 2);
      chk("centre_f3_2525", res[(25*OW+25)*NF+3], 52);
      chk("centre_f3_0307", res[(3*OW+7)*NF+3], 12);
      chk("centre_f5_bias", res[5], 35);

      // negative sums, with a 7-cycle output stall and writes attempted while busy
      load(2);
      run_image("neg", 0, 37, 1, -1);
`ifdef CONV_STREAM_RELU_EN
      chk("neg_value", res[0], 0);
`else
      chk("neg_value", res[0], -4);
`endif
      for (int i = 0; i < NOUT; i++) res_prev[i] = res[i];
      run_image("neg_again", 0, -1, 0, -1);
      begin
         int diffs;
         diffs = 0;
         for (int i = 0; i < NOUT; i++) if (res[i] !== res_prev[i]) diffs++;
         chk("busy_write_ignored", diffs, 0);
      end

      // reset in the middle of an image
      load(0);
      run_image("abort", 0, -1, 0, 300);
      #3 reset_n = 1'b0;
      #1;
      chk("midrst_flags", {bus_if.in_ready, bus_if.out_valid, bus_if.out_last, bus_if.busy, bus_if.done}, 5'b0);
      chk("midrst_out_data", bus_if.out_data, 0);
      chk("midrst_coords", {bus_if.out_f, bus_if.out_row, bus_if.out_col}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      load(0);
      run_image("ones_rerun", 0, -1, 0, -1);
      chk("rerun_first", res[0], 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
